// File: rtl/sprite_fb_writer.sv
// sprite_fb_writer: write-side FIFO between the sprite renderer and the framebuffer BRAM.
//
// Pixels (address + colour index) are queued one per cycle and retired into the framebuffer
// only on cycles where the write port is granted. A flush handshake drains the queue and
// pulses flush_done once every queued pixel has been written.
//
// Optional feature macro: SPRITE_FB_TRANSPARENCY_EN
//   defined   - pixels equal to TRANSPARENT are accepted but dropped (never written)
//   undefined - every accepted pixel is written; TRANSPARENT has no effect
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    pixel handshake from the renderer
//   in_addr, in_pix      linear pixel address and colour index
//   fb_grant             framebuffer write port free this cycle
//   fb_we, fb_addr,      write strobe, word address, data (nibble-replicated when PACKED)
//   fb_wdata, fb_wmask   and nibble enables; address/data/mask always show the FIFO head
//   flush_req            level request to drain the FIFO
//   flush_done           one-cycle pulse when the drain completes
//   count                current FIFO occupancy
module sprite_fb_writer #(
  parameter int unsigned      ADDRW       = 19,
  parameter int unsigned      DATAW       = 4,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      PACKED      = 1,
  parameter logic [DATAW-1:0] TRANSPARENT = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDRW-1:0]           in_addr,
  input  logic [DATAW-1:0]           in_pix,
  input  logic                       fb_grant,
  output logic                       fb_we,
  output logic [ADDRW-1:0]           fb_addr,
  output logic [2*DATAW-1:0]         fb_wdata,
  output logic [1:0]                 fb_wmask,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ADDRW + 1 + DATAW;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_d;

  logic            w_hs, w_is_key, w_drop, w_push, w_pop;
  logic [ADDRW-1:0] w_wr_addr;
  logic            w_wr_sel;
  logic [EW-1:0]   w_head;
  logic [DATAW-1:0] w_head_pix;

  // Handshake and push are separate: a keyed pixel still consumes in_ready.
  assign in_ready = (r_state == StRun) && (r_count < Full);
  assign w_hs     = in_valid && in_ready;
  assign w_is_key = (in_pix == TRANSPARENT);
`ifdef SPRITE_FB_TRANSPARENCY_EN
  assign w_drop   = w_is_key;
`else
  // Key compare is still elaborated so the parameter stays referenced; dropping is disabled.
  assign w_drop   = w_is_key & 1'b0;
`endif
  assign w_push   = w_hs && !w_drop;
  assign w_pop    = fb_grant && (r_count != '0);

  // Address split and nibble select are resolved at push time and stored with the pixel.
  assign w_wr_addr = (PACKED != 0) ? (in_addr >> 1) : in_addr;
  assign w_wr_sel  = (PACKED != 0) ? in_addr[0] : 1'b0;

  assign w_head     = r_mem[r_rptr];
  assign w_head_pix = w_head[DATAW-1:0];
  assign fb_we      = w_pop;
  assign fb_addr    = w_head[EW-1 -: ADDRW];
  assign fb_wdata   = (PACKED != 0) ? {w_head_pix, w_head_pix} : {{DATAW{1'b0}}, w_head_pix};
  assign fb_wmask   = w_head[DATAW] ? 2'b10 : 2'b01;
  assign count      = r_count;
  // Decoded from the state register, so the pulse is glitch-free.
  assign flush_done = (r_state == StDone);

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:   if (flush_req) w_state_d = StDrain;
      // Looks at next count so a final pop this cycle completes the drain.
      StDrain: if (w_count_d == '0) w_state_d = StDone;
      StDone:  w_state_d = flush_req ? StDrain : StRun;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_wr_addr, w_wr_sel, in_pix};
  end

endmodule

// File: tb/tb_sprite_fb_writer.sv
module tb_sprite_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [18:0] in_addr;
  logic [3:0]  in_pix;
  logic        fb_grant, fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic [1:0]  fb_wmask;
  logic        flush_req, flush_done;
  logic [4:0]  count;

  sprite_fb_writer #(
    .ADDRW(19), .DATAW(4), .DEPTH(16), .PACKED(1), .TRANSPARENT(4'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_pix(in_pix),
    .fb_grant(fb_grant), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_wmask(fb_wmask), .flush_req(flush_req), .flush_done(flush_done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
    logic [1:0]  m;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  int   cyc      = 0;
  int   last_wr_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input logic [18:0] a, input logic [3:0] p);
    exp_t e;
    e.a = a >> 1;
    e.d = {p, p};
    e.m = a[0] ? 2'b10 : 2'b01;
    return e;
  endfunction

  function automatic bit dropped(input logic [3:0] p);
`ifdef SPRITE_FB_TRANSPARENCY_EN
    return (p == 4'h0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every framebuffer write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {45'd0, fb_addr}, 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", fb_addr, e.a);
          chk("wr_data", fb_wdata, e.d);
          chk("wr_mask", fb_wmask, e.m);
        end
        n_writes++;
        last_wr_cyc = cyc;
      end
      if (flush_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_one(input logic [18:0] a, input logic [3:0] p);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_pix   = p;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("push_ready", in_ready, 1);
    if (in_ready && !dropped(p)) exp_q.push_back(mk(a, p));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int waited;
    waited = 0;
    @(negedge clk);
    while (count != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk(name, count, 0);
    @(posedge clk);
    #1;
  endtask

  int grant_tab[10] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1};
  int cnt_tab[10]   = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
  int w0, c0, seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_pix = '0;
    fb_grant = 1'b0; flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_done", flush_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single pixel at an odd address, granted port: write in the following cycle.
    fb_grant = 1'b1;
    push_one(19'h00005, 4'hA);
    chk("single_cnt", count, 1);
    @(negedge clk);
    chk("single_we", fb_we, 1);
    @(posedge clk);
    #1;
    chk("single_cnt_after", count, 0);

    // Fill the FIFO with the port denied; the 17th pixel must be held off.
    fb_grant = 1'b0;
    for (int i = 0; i < 16; i++) push_one(19'd100 + 19'(i), 4'(i));
    @(negedge clk);
    chk("full_cnt", count, 16);
    chk("full_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_addr = 19'd999; in_pix = 4'h9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready", in_ready, 0);
      chk("hold_cnt", count, 16);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fb_grant = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("burst_we", fb_we, 1);
    end
    @(negedge clk);
    chk("burst_we_end", fb_we, 0);
    chk("burst_cnt_end", count, 0);
    @(posedge clk);
    #1;

    // Streaming with steady then toggled grant.
    for (int i = 0; i < 10; i++) begin
      fb_grant = grant_tab[i][0];
      push_one(19'h00400 + 19'(i), 4'(i + 3));
      chk("stream_cnt", count, 5'(cnt_tab[i]));
    end
    fb_grant = 1'b1;
    wait_drain("stream_drain");

    // Flush with 5 queued pixels; grant raised 3 cycles into the drain.
    fb_grant = 1'b0;
    for (int i = 0; i < 5; i++) push_one(19'd200 + 19'(i), 4'(i + 1));
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    done_cnt = 0;
    w0 = n_writes;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (flush_done) seen = 1;
      else begin
        chk("drain_ready", in_ready, 0);
        @(posedge clk);
        #1;
        if (k == 2) fb_grant = 1'b1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("flush_seen", seen, 1);
    chk("flush_pulses", done_cnt, 1);
    chk("flush_writes", n_writes - w0, 5);
    chk("flush_timing", done_cyc, last_wr_cyc + 1);

    // Flush on an empty FIFO.
    c0 = cyc;
    done_cnt = 0;
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("empty_flush_pulses", done_cnt, 1);
    chk("empty_flush_timing", done_cyc, c0 + 2);

    // Colour-key sequence 0,3,0,7.
    fb_grant = 1'b0;
    w0 = n_writes;
    push_one(19'h00300, 4'h0);
    push_one(19'h00301, 4'h3);
    push_one(19'h00302, 4'h0);
    push_one(19'h00303, 4'h7);
`ifdef SPRITE_FB_TRANSPARENCY_EN
    chk("key_cnt", count, 2);
`else
    chk("key_cnt", count, 4);
`endif
    fb_grant = 1'b1;
    wait_drain("key_drain");
`ifdef SPRITE_FB_TRANSPARENCY_EN
    chk("key_writes", n_writes - w0, 2);
`else
    chk("key_writes", n_writes - w0, 4);
`endif

    // Reset mid-cycle with 8 queued pixels: nothing may be written afterwards.
    fb_grant = 1'b0;
    for (int i = 0; i < 8; i++) push_one(19'd500 + 19'(i), 4'(i + 2));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_we", fb_we, 0);
    chk("mid_rst_done", flush_done, 0);
    exp_q.delete();
    w0 = n_writes;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fb_grant = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_cnt", count, 0);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_writes", n_writes - w0, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_fb_writer.md
# sprite_fb_writer

Write-side buffer between the sprite renderer and the framebuffer BRAM. It accepts one pixel per cycle (pixel address plus colour index), queues it in a small FIFO, and retires it into the framebuffer only on cycles when the framebuffer write port is granted. Colour-key transparency is optional. A flush handshake lets the frame sequencer confirm that every queued pixel has landed before a buffer swap.

## Interface
Parameters:
- ADDRW, 19, pixel address width; matches the renderer's `addr` output.
- DATAW, 4, colour-index width.
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- PACKED, 1, when 1 the framebuffer holds two pixels per byte.
- TRANSPARENT, 4'h0, colour key; used only when the transparency macro is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  pixel offered; driven by the renderer's `drawing`.
- in_ready  out  1  FIFO can accept a pixel this cycle.
- in_addr  in  ADDRW  linear pixel address, y*800+x.
- in_pix  in  DATAW  colour index.
- fb_grant  in  1  framebuffer write port is free this cycle.
- fb_we  out  1  write strobe.
- fb_addr  out  ADDRW  word address; in_addr>>1 when PACKED, else in_addr.
- fb_wdata  out  2*DATAW  colour index replicated into both nibbles (PACKED); otherwise low DATAW bits are the pixel and the upper bits are 0.
- fb_wmask  out  2  nibble enables. PACKED: in_addr[0]=0 gives 2'b01, in_addr[0]=1 gives 2'b10. Unpacked: always 2'b01.
- flush_req  in  1  level; request to drain the FIFO.
- flush_done  out  1  one-cycle pulse when the drain completes.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Each FIFO entry stores {fb_addr, nibble select, pix}, with address split and mask computed at push time.
- A push occurs on a cycle where in_valid && in_ready.
- in_ready = (state==RUN) && (count<DEPTH). Full blocks a push even if a pop happens in the same cycle.
- A pop occurs on a cycle where fb_grant && count!=0. fb_we = fb_grant && count!=0, combinational.
- fb_addr, fb_wdata and fb_wmask always present the FIFO head. They are don't-care while fb_we=0.
- Push and pop in the same cycle leave count unchanged. Read and write pointers wrap modulo DEPTH.
- State machine:
  - RUN moves to DRAIN when flush_req=1. While in DRAIN, in_ready=0.
  - DRAIN moves to DONE when count==0, including a count that reaches 0 through a pop that cycle. A flush with an empty FIFO therefore reaches DONE the next cycle.
  - DONE lasts one cycle and asserts flush_done. It then returns to RUN, or to DRAIN if flush_req is still high.
  - flush_req arriving in the same cycle as a push: the push completes, then the block enters DRAIN.
- Reset values: state=RUN, count=0, pointers=0, flush_done=0. fb_we=0 because count=0. in_ready=1 once rst_n is released.
- Reset asserted mid-operation discards all queued pixels. No write is issued for them.
- Overflow cannot occur. A pop on an empty FIFO cannot occur.

## Timing
- Push to earliest fb_we is 1 cycle: a pixel accepted at edge N can be written in the cycle following edge N.
- There is no bypass path. An empty FIFO with fb_grant=1 produces no write in the cycle of the push.
- Sustained throughput is 1 pixel/cycle while fb_grant stays high.
- in_ready drops in the cycle after the push that fills the FIFO.
- flush_done is registered. It rises 1 cycle after the cycle in which count becomes 0 during DRAIN.

## Configuration
- SPRITE_FB_TRANSPARENCY_EN defined:
  - A pixel with in_pix==TRANSPARENT is handshaken (it consumes in_ready) but is not pushed.
  - count does not change for it, and no framebuffer write occurs for it.
- SPRITE_FB_TRANSPARENCY_EN undefined:
  - Every accepted pixel is pushed and written, including TRANSPARENT.
  - The TRANSPARENT parameter is ignored.

## Test plan
- Reset release, then push addr=0x00005 pix=4'hA with fb_grant=1.
  - Next cycle: fb_we=1, fb_addr=0x00002, fb_wdata=8'hAA, fb_wmask=2'b10. count returns to 0.
- Hold fb_grant=0 and push 17 pixels with DEPTH=16.
  - After 16 accepts, in_ready=0 and count=16. The 17th pixel is held by the source.
  - Raise fb_grant: 16 writes occur in FIFO order on consecutive cycles.
- Continuous push with fb_grant=1.
  - count stays at 1 and one write per cycle occurs.
  - Toggle fb_grant every other cycle: count grows by 1 on each denied cycle, and writes retain order.
- Queue 5 pixels with fb_grant=0, pulse flush_req=1, then raise fb_grant after 3 cycles.
  - in_ready=0 throughout the drain.
  - flush_done pulses once, 1 cycle after the 5th write.
  - Flush with an empty FIFO: flush_done 2 cycles after flush_req.
- With SPRITE_FB_TRANSPARENCY_EN defined, push pix sequence 0,3,0,7.
  - Only pixels 3 and 7 are written and count peaks at 2. Without the macro, 4 writes occur.
- Queue 8 pixels, then assert rst_n=0 asynchronously mid-cycle.
  - count=0, fb_we=0 and flush_done=0 immediately.
  - No stale writes occur after release.
